// File: rtl/enemy_row_render_hit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enemy_row_render_hit_pkg
// Purpose  : Shared invader-row geometry and collision-scan state encoding.
//            The bullet and score blocks use the same geometry constants.
// Contents : c_N_ENEMIES, c_ENEMY_W, c_ENEMY_H, c_SPACING, c_ROW_Y,
//            c_ENEMY_RGB, scan_state_t (IDLE/SCAN/HIT)
// Revision : 1.0 - initial release
// ============================================================================
package enemy_row_render_hit_pkg;

  localparam int           c_N_ENEMIES = 8;
  localparam int           c_ENEMY_W   = 16;
  localparam int           c_ENEMY_H   = 12;
  localparam int           c_SPACING   = 32;
  localparam int           c_ROW_Y     = 60;
  localparam logic [2:0]   c_ENEMY_RGB = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HIT  = 2'd2
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/enemy_row_render_hit_if.sv
`default_nettype none
// ============================================================================
// Module   : enemy_row_render_hit_if
// Purpose  : Bundle of video, bullet and status signals between the invader
//            row block (slave) and the game logic / VGA mixer (master).
// Ports    : restart, posx, pixel_x/y, video_on, frame_tick, bullet_x/y,
//            bullet_active (master -> slave); enemy_on, enemy_rgb, hit,
//            hit_index, alive_mask, all_dead, scan_busy (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface enemy_row_render_hit_if #(
  parameter int N_ENEMIES = 8
);
  logic                 restart;
  logic [10:0]          posx;
  logic [9:0]           pixel_x;
  logic [9:0]           pixel_y;
  logic                 video_on;
  logic                 frame_tick;
  logic [9:0]           bullet_x;
  logic [9:0]           bullet_y;
  logic                 bullet_active;
  logic                 enemy_on;
  logic [2:0]           enemy_rgb;
  logic                 hit;
  logic [3:0]           hit_index;
  logic [N_ENEMIES-1:0] alive_mask;
  logic                 all_dead;
  logic                 scan_busy;

  modport master (
    output restart, posx, pixel_x, pixel_y, video_on, frame_tick,
           bullet_x, bullet_y, bullet_active,
    input  enemy_on, enemy_rgb, hit, hit_index, alive_mask, all_dead, scan_busy
  );

  modport slave (
    input  restart, posx, pixel_x, pixel_y, video_on, frame_tick,
           bullet_x, bullet_y, bullet_active,
    output enemy_on, enemy_rgb, hit, hit_index, alive_mask, all_dead, scan_busy
  );
endinterface
`default_nettype wire

// File: rtl/enemy_slot_decode.sv
`default_nettype none
// ============================================================================
// Module   : enemy_slot_decode
// Purpose  : Combinational point-vs-row decode shared by rendering and the
//            bullet collision compare.
// Ports    : posx      in  11  left edge of slot 0
//            x         in  11  zero-extended column under test
//            y         in  10  row under test
//            in_row    out  1  y inside the invader band
//            slot      out  4  slot number covering x
//            in_sprite out  1  x inside the row and inside a sprite body
// Revision : 1.0 - initial release
// ============================================================================
module enemy_slot_decode #(
  parameter int N_ENEMIES = 8,
  parameter int ENEMY_W   = 16,
  parameter int ENEMY_H   = 12,
  parameter int SPACING   = 32,
  parameter int ROW_Y     = 60
) (
  input  wire logic [10:0] posx,
  input  wire logic [10:0] x,
  input  wire logic [9:0]  y,
  output logic             in_row,
  output logic [3:0]       slot,
  output logic             in_sprite
);
  localparam int          c_SHIFT   = $clog2(SPACING);
  localparam logic [10:0] c_ROW_LEN = 11'(N_ENEMIES * SPACING);

  // 12-bit signed difference: columns left of posx go negative instead of
  // wrapping into a high slot.
  logic signed [11:0] w_dx;
  logic               w_x_in_range;

  assign w_dx         = $signed({1'b0, x}) - $signed({1'b0, posx});
  assign w_x_in_range = !w_dx[11] && (w_dx[10:0] < c_ROW_LEN);
  assign slot         = w_dx[c_SHIFT +: 4];
  assign in_sprite    = w_x_in_range && (w_dx[c_SHIFT-1:0] < c_SHIFT'(ENEMY_W));
  assign in_row       = (y >= 10'(ROW_Y)) && (y < 10'(ROW_Y + ENEMY_H));

endmodule
`default_nettype wire

// File: rtl/enemy_row_render_hit.sv
`default_nettype none
// ============================================================================
// Module   : enemy_row_render_hit
// Purpose  : Renders one row of invaders and, once per frame, scans the row
//            against the player bullet, killing at most one invader.
// Ports    : clk    in  system clock
//            reset  in  asynchronous active-low reset
//            bus    slave modport of enemy_row_render_hit_if
// Revision : 1.0 - initial release
// ============================================================================
module enemy_row_render_hit
  import enemy_row_render_hit_pkg::*;
#(
  parameter int         N_ENEMIES = c_N_ENEMIES,
  parameter int         ENEMY_W   = c_ENEMY_W,
  parameter int         ENEMY_H   = c_ENEMY_H,
  parameter int         SPACING   = c_SPACING,
  parameter int         ROW_Y     = c_ROW_Y,
  parameter logic [2:0] ENEMY_RGB = c_ENEMY_RGB
) (
  input wire logic              clk,
  input wire logic              reset,
  enemy_row_render_hit_if.slave bus
);
  scan_state_t          r_state;
  scan_state_t          w_next_state;
  logic [3:0]           r_idx;
  logic [10:0]          r_px;
  logic [9:0]           r_bx;
  logic [9:0]           r_by;
  logic [N_ENEMIES-1:0] r_alive;
  logic                 r_all_dead;
  logic                 r_hit;
  logic [3:0]           r_hit_index;
  logic                 r_enemy_on;
  logic [2:0]           r_enemy_rgb;

  logic                 w_pix_in_row, w_pix_in_sprite;
  logic [3:0]           w_pix_slot;
  logic                 w_bul_in_row, w_bul_in_sprite;
  logic [3:0]           w_bul_slot;
  logic [15:0]          w_alive_ext;
  logic                 w_pix_on;
  logic                 w_overlap;
  logic                 w_last_idx;
  logic                 w_kill;

  // Padded copy so a 4-bit slot index is always in range.
  assign w_alive_ext = 16'(r_alive);

  enemy_slot_decode #(
    .N_ENEMIES(N_ENEMIES), .ENEMY_W(ENEMY_W), .ENEMY_H(ENEMY_H),
    .SPACING(SPACING), .ROW_Y(ROW_Y)
  ) u_pix_decode (
    .posx(bus.posx), .x({1'b0, bus.pixel_x}), .y(bus.pixel_y),
    .in_row(w_pix_in_row), .slot(w_pix_slot), .in_sprite(w_pix_in_sprite)
  );

  // Collision decode runs on the values latched at frame_tick so the scan
  // stays consistent while posx moves during the frame.
  enemy_slot_decode #(
    .N_ENEMIES(N_ENEMIES), .ENEMY_W(ENEMY_W), .ENEMY_H(ENEMY_H),
    .SPACING(SPACING), .ROW_Y(ROW_Y)
  ) u_bul_decode (
    .posx(r_px), .x({1'b0, r_bx}), .y(r_by),
    .in_row(w_bul_in_row), .slot(w_bul_slot), .in_sprite(w_bul_in_sprite)
  );

  assign w_pix_on   = bus.video_on && w_pix_in_row && w_pix_in_sprite &&
                      w_alive_ext[w_pix_slot];
  assign w_overlap  = w_bul_in_row && w_bul_in_sprite &&
                      (w_bul_slot == r_idx) && w_alive_ext[r_idx];
  assign w_last_idx = (r_idx == 4'(N_ENEMIES - 1));
  assign w_kill     = (r_state == HIT) && !bus.restart;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.restart) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: if (bus.frame_tick && bus.bullet_active) w_next_state = SCAN;
        SCAN: begin
          if (w_overlap)       w_next_state = HIT;
          else if (w_last_idx) w_next_state = IDLE;
        end
        HIT:     w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= 4'd0;
      r_px        <= 11'd0;
      r_bx        <= 10'd0;
      r_by        <= 10'd0;
      r_alive     <= '1;
      r_all_dead  <= 1'b0;
      r_hit       <= 1'b0;
      r_hit_index <= 4'd0;
      r_enemy_on  <= 1'b0;
      r_enemy_rgb <= 3'b000;
    end else begin
      if (r_state == IDLE && w_next_state == SCAN) begin
        r_px  <= bus.posx;
        r_bx  <= bus.bullet_x;
        r_by  <= bus.bullet_y;
        r_idx <= 4'd0;
      end else if (r_state == SCAN && w_next_state == SCAN) begin
        r_idx <= r_idx + 4'd1;
      end

      if (bus.restart) begin
        r_alive <= '1;
      end else if (r_state == HIT) begin
        r_alive <= r_alive & ~(N_ENEMIES'(1) << r_idx);
      end

      // Kill event and mask update become visible together, after HIT.
      r_hit <= w_kill;
      if (w_kill) r_hit_index <= r_idx;

      r_all_dead  <= (r_alive == '0);
      r_enemy_on  <= w_pix_on;
      r_enemy_rgb <= w_pix_on ? ENEMY_RGB : 3'b000;
    end
  end

  assign bus.enemy_on   = r_enemy_on;
  assign bus.enemy_rgb  = r_enemy_rgb;
  assign bus.hit        = r_hit;
  assign bus.hit_index  = r_hit_index;
  assign bus.alive_mask = r_alive;
  assign bus.all_dead   = r_all_dead;
  assign bus.scan_busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_enemy_row_render_hit.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_row_render_hit
// Purpose  : Self-checking bench for enemy_row_render_hit: render vectors
//            from a table, then kill/scan/restart/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_row_render_hit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  enemy_row_render_hit_if #(.N_ENEMIES(8)) bus ();

  enemy_row_render_hit #(
    .N_ENEMIES(8), .ENEMY_W(16), .ENEMY_H(12), .SPACING(32), .ROW_Y(60),
    .ENEMY_RGB(3'b010)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] posx;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        vid;
    logic        exp_on;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic render_check(input string name, input logic [10:0] posx,
                              input logic [9:0] px, input logic [9:0] py,
                              input logic vid, input logic exp_on);
    bus.posx = posx; bus.pixel_x = px; bus.pixel_y = py; bus.video_on = vid;
    step();
    check({name, "_on"}, 32'(bus.enemy_on), 32'(exp_on));
    check({name, "_rgb"}, 32'(bus.enemy_rgb), exp_on ? 32'h2 : 32'h0);
  endtask

  // Issues one frame_tick and follows the scan until the FSM is idle again
  // or a hit appears. hit_cyc counts samples after the tick edge (0 = none).
  task automatic run_frame(input logic [9:0] bx, input logic [9:0] by, input logic act,
                           output int hit_cyc, output int busy_cnt, output logic [3:0] hidx);
    logic done;
    bus.bullet_x = bx; bus.bullet_y = by; bus.bullet_active = act;
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    hit_cyc = 0; busy_cnt = 0; hidx = 4'd0; done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.scan_busy) busy_cnt++;
      if (bus.hit) begin
        hit_cyc = c; hidx = bus.hit_index; done = 1'b1;
        break;
      end
      if (!bus.scan_busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check("frame_timeout", 32'(done), 32'h1);
  endtask

  initial begin
    int          hc, bc;
    logic [3:0]  hi;
    logic        seen_hit;

    vecs[0]  = '{11'd100,  10'd100,  10'd60, 1'b1, 1'b1};
    vecs[1]  = '{11'd100,  10'd116,  10'd60, 1'b1, 1'b0};
    vecs[2]  = '{11'd100,  10'd132,  10'd71, 1'b1, 1'b1};
    vecs[3]  = '{11'd100,  10'd132,  10'd72, 1'b1, 1'b0};
    vecs[4]  = '{11'd100,  10'd132,  10'd59, 1'b1, 1'b0};
    vecs[5]  = '{11'd100,  10'd99,   10'd60, 1'b1, 1'b0};
    vecs[6]  = '{11'd100,  10'd339,  10'd60, 1'b1, 1'b1};
    vecs[7]  = '{11'd100,  10'd340,  10'd60, 1'b1, 1'b0};
    vecs[8]  = '{11'd100,  10'd356,  10'd60, 1'b1, 1'b0};
    vecs[9]  = '{11'd100,  10'd100,  10'd60, 1'b0, 1'b0};
    vecs[10] = '{11'd2040, 10'd0,    10'd60, 1'b1, 1'b0};
    vecs[11] = '{11'd0,    10'd0,    10'd60, 1'b1, 1'b1};
    vecs[12] = '{11'd1000, 10'd1015, 10'd65, 1'b1, 1'b1};
    vecs[13] = '{11'd1000, 10'd1023, 10'd65, 1'b1, 1'b0};
    vecs[14] = '{11'd10,   10'd5,    10'd60, 1'b1, 1'b0};

    bus.restart = 1'b0; bus.posx = 11'd100; bus.pixel_x = 10'd100;
    bus.pixel_y = 10'd60; bus.video_on = 1'b1; bus.frame_tick = 1'b0;
    bus.bullet_x = 10'd0; bus.bullet_y = 10'd0; bus.bullet_active = 1'b0;

    // Reset state, held over a few edges with a pixel that would be lit.
    repeat (3) step();
    check("rst_enemy_on", 32'(bus.enemy_on), 32'h0);
    check("rst_rgb", 32'(bus.enemy_rgb), 32'h0);
    check("rst_hit", 32'(bus.hit), 32'h0);
    check("rst_hit_index", 32'(bus.hit_index), 32'h0);
    check("rst_alive", 32'(bus.alive_mask), 32'hFF);
    check("rst_all_dead", 32'(bus.all_dead), 32'h0);
    check("rst_busy", 32'(bus.scan_busy), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      render_check($sformatf("vec%0d", i), vecs[i].posx, vecs[i].px,
                   vecs[i].py, vecs[i].vid, vecs[i].exp_on);
    end

    // Kill slot 2: SCAN idx0..2, HIT, then hit visible with FSM idle.
    bus.posx = 11'd100;
    run_frame(10'd168, 10'd65, 1'b1, hc, bc, hi);
    check("k2_hit_cycle", 32'(hc), 32'd5);
    check("k2_busy_cycles", 32'(bc), 32'd4);
    check("k2_hit_index", 32'(hi), 32'd2);
    check("k2_alive", 32'(bus.alive_mask), 32'hFB);
    step();
    check("k2_hit_width", 32'(bus.hit), 32'h0);
    check("k2_all_dead", 32'(bus.all_dead), 32'h0);

    render_check("gap164", 11'd100, 10'd164, 10'd60, 1'b1, 1'b0);
    render_check("gap179", 11'd100, 10'd179, 10'd60, 1'b1, 1'b0);
    render_check("slot3", 11'd100, 10'd196, 10'd60, 1'b1, 1'b1);

    // Same bullet again: slot 2 is dead, full 8-slot scan, no hit.
    run_frame(10'd168, 10'd65, 1'b1, hc, bc, hi);
    check("miss_hit_cycle", 32'(hc), 32'd0);
    check("miss_busy_cycles", 32'(bc), 32'd8);
    check("miss_hit_index_held", 32'(bus.hit_index), 32'd2);
    check("miss_alive", 32'(bus.alive_mask), 32'hFB);

    // Tick with no bullet in flight.
    run_frame(10'd168, 10'd65, 1'b0, hc, bc, hi);
    check("inactive_busy", 32'(bc), 32'd0);
    step();
    check("inactive_busy2", 32'(bus.scan_busy), 32'h0);

    // Restart while scanning idx1 with a bullet over slot 5.
    bus.bullet_x = 10'd263; bus.bullet_y = 10'd65; bus.bullet_active = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    check("rs_busy_idx0", 32'(bus.scan_busy), 32'h1);
    step();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    check("rs_busy", 32'(bus.scan_busy), 32'h0);
    check("rs_alive", 32'(bus.alive_mask), 32'hFF);
    seen_hit = bus.hit;
    for (int c = 0; c < 10; c++) begin
      step();
      seen_hit = seen_hit | bus.hit;
    end
    check("rs_no_hit", 32'(seen_hit), 32'h0);

    // Kill every invader, one per frame.
    for (int k = 0; k < 8; k++) begin
      run_frame(10'(100 + 32 * k + 5), 10'd65, 1'b1, hc, bc, hi);
      check($sformatf("kill%0d_index", k), 32'(hi), 32'(k));
      check($sformatf("kill%0d_cycle", k), 32'(hc), 32'(k + 3));
    end
    check("kill_alive_zero", 32'(bus.alive_mask), 32'h0);
    check("kill_all_dead_lag", 32'(bus.all_dead), 32'h0);
    step();
    check("kill_all_dead", 32'(bus.all_dead), 32'h1);

    // Asynchronous reset mid-cycle.
    #3;
    reset = 1'b0;
    #1;
    check("areset_all_dead", 32'(bus.all_dead), 32'h0);
    check("areset_alive", 32'(bus.alive_mask), 32'hFF);
    check("areset_hit_index", 32'(bus.hit_index), 32'h0);
    check("areset_busy", 32'(bus.scan_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
